// File: rtl/absorb_block_framer.sv
// Cuts a w-bit message stream into RATE_WORDS-word blocks and drives the SHAKE padding controls.
// Optional build macro ABSORB_ZERO_MASK_EN zeroes message bytes beyond din_bytes in data_out.

module absorb_block_framer_chk #(
    parameter int BYTES = 8,
    parameter int BW    = 4
) (
    input logic          clk,
    input logic          rst,
    input logic          din_valid,
    input logic          din_ready,
    input logic          din_last,
    input logic [BW-1:0] din_bytes
);
    // A short word may only close the message, and never exceeds the word size
    a_din_legal: assert property (@(posedge clk) disable iff (rst)
        (din_valid && din_ready) |->
            ((din_bytes <= BW'(BYTES)) && (din_last || (din_bytes == BW'(BYTES)))));
endmodule

module absorb_block_framer #(
    parameter int W          = 64,
    parameter int RATE_WORDS = 17,
    localparam int BYTES     = W / 8,
    localparam int BW        = $clog2(BYTES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  din,
    input  logic [BW-1:0] din_bytes,
    input  logic          din_last,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [W-1:0]  data_out,
    output logic [BW-1:0] remaining_valid_bytes,
    output logic          padding_enable,
    output logic          last_word_in_block,
    output logic          padding_reset,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          absorb_done
);
    localparam int CW = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
    localparam logic [CW-1:0] LAST_CNT   = CW'(RATE_WORDS - 1);
    localparam logic [BW-1:0] FULL_BYTES = BW'(BYTES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ABSORB = 2'd1,
        S_PAD    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   word_cnt_r, word_cnt_s;
    logic [W-1:0]    data_out_r, ld_data_s, din_word_s;
    logic [BW-1:0]   rvb_r, ld_rvb_s;
    logic            pe_r, ld_pe_s;
    logic            lwib_r, ld_lwib_s;
    logic            out_valid_r, load_s;
    logic            absorb_done_r, done_s;
    logic            padding_reset_r, preset_s;
    logic            can_load_s, cnt_last_s, accept_s, din_ready_s;
    logic [CW-1:0]   cnt_next_s;

`ifdef ABSORB_ZERO_MASK_EN
    function automatic logic [W-1:0] mask_bytes(input logic [W-1:0] word, input logic [BW-1:0] nbytes);
        logic [W-1:0] m;
        m = word;
        for (int k = 0; k < BYTES; k++) begin
            if (k >= int'(nbytes)) begin
                m[W-1-8*k -: 8] = 8'h00;
            end else begin
                m[W-1-8*k -: 8] = word[W-1-8*k -: 8];
            end
        end
        return m;
    endfunction

    assign din_word_s = mask_bytes(din, din_bytes);
`else
    assign din_word_s = din;
`endif

    // The single output register can take a new word when empty or draining this cycle
    assign can_load_s  = !out_valid_r || out_ready;
    assign cnt_last_s  = (word_cnt_r == LAST_CNT);
    assign cnt_next_s  = cnt_last_s ? {CW{1'b0}} : (word_cnt_r + CW'(1));
    assign din_ready_s = (state_r == S_ABSORB) && can_load_s;
    assign accept_s    = din_valid && din_ready_s;

    // Next-state and output-register load decode
    always_comb begin
        state_s    = state_r;
        word_cnt_s = word_cnt_r;
        load_s     = 1'b0;
        ld_data_s  = {W{1'b0}};
        ld_rvb_s   = {BW{1'b0}};
        ld_pe_s    = 1'b0;
        ld_lwib_s  = 1'b0;
        done_s     = 1'b0;
        preset_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s    = S_ABSORB;
                    word_cnt_s = {CW{1'b0}};
                    preset_s   = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ABSORB: begin
                if (accept_s) begin
                    load_s     = 1'b1;
                    ld_data_s  = din_word_s;
                    ld_rvb_s   = din_bytes;
                    ld_pe_s    = (din_bytes < FULL_BYTES);
                    ld_lwib_s  = cnt_last_s;
                    word_cnt_s = cnt_next_s;
                    // A short word that closes the block already carries the pad end
                    if (din_last) begin
                        if (ld_pe_s && cnt_last_s) begin
                            state_s = S_FINISH;
                        end else begin
                            state_s = S_PAD;
                        end
                    end else begin
                        state_s = S_ABSORB;
                    end
                end else begin
                    state_s = S_ABSORB;
                end
            end
            S_PAD: begin
                if (can_load_s) begin
                    load_s     = 1'b1;
                    ld_pe_s    = 1'b1;
                    ld_lwib_s  = cnt_last_s;
                    word_cnt_s = cnt_next_s;
                    if (cnt_last_s) begin
                        state_s = S_FINISH;
                    end else begin
                        state_s = S_PAD;
                    end
                end else begin
                    state_s = S_PAD;
                end
            end
            S_FINISH: begin
                if (out_valid_r && out_ready) begin
                    done_s   = 1'b1;
                    preset_s = 1'b1;
                    state_s  = S_IDLE;
                end else begin
                    state_s = S_FINISH;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, word counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= S_IDLE;
            word_cnt_r      <= {CW{1'b0}};
            data_out_r      <= {W{1'b0}};
            rvb_r           <= {BW{1'b0}};
            pe_r            <= 1'b0;
            lwib_r          <= 1'b0;
            out_valid_r     <= 1'b0;
            absorb_done_r   <= 1'b0;
            padding_reset_r <= 1'b0;
        end else begin
            state_r         <= state_s;
            word_cnt_r      <= word_cnt_s;
            absorb_done_r   <= done_s;
            padding_reset_r <= preset_s;
            if (load_s) begin
                data_out_r  <= ld_data_s;
                rvb_r       <= ld_rvb_s;
                pe_r        <= ld_pe_s;
                lwib_r      <= ld_lwib_s;
                out_valid_r <= 1'b1;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign din_ready             = din_ready_s;
    assign data_out              = data_out_r;
    assign remaining_valid_bytes = rvb_r;
    assign padding_enable        = pe_r;
    assign last_word_in_block    = lwib_r;
    assign out_valid             = out_valid_r;
    assign absorb_done           = absorb_done_r;
    assign padding_reset         = padding_reset_r;

    absorb_block_framer_chk #(
        .BYTES (BYTES),
        .BW    (BW)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din_ready (din_ready_s),
        .din_last  (din_last),
        .din_bytes (din_bytes)
    );
endmodule

// File: tb/tb_absorb_block_framer.sv
// Scoreboard bench for absorb_block_framer: random messages against a block/padding reference model.

module tb_absorb_block_framer;
    localparam int RW = 17;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [63:0] din = 64'd0;
    logic [3:0]  din_bytes = 4'd0;
    logic        din_last = 1'b0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [63:0] data_out;
    logic [3:0]  remaining_valid_bytes;
    logic        padding_enable;
    logic        last_word_in_block;
    logic        padding_reset;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        absorb_done;

    absorb_block_framer #(.W(64), .RATE_WORDS(RW)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .din                   (din),
        .din_bytes             (din_bytes),
        .din_last              (din_last),
        .din_valid             (din_valid),
        .din_ready             (din_ready),
        .data_out              (data_out),
        .remaining_valid_bytes (remaining_valid_bytes),
        .padding_enable        (padding_enable),
        .last_word_in_block    (last_word_in_block),
        .padding_reset         (padding_reset),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .absorb_done           (absorb_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  rvb;
        logic        pe;
        logic        lwib;
        logic        fin;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   ready_mode = 0;
    bit   gaps = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: bytes at index >= nb are zero when masking is built in
    function automatic logic [63:0] model_data(input logic [63:0] w, input int nb);
        logic [63:0] keep;
        keep = ~(64'hFFFF_FFFF_FFFF_FFFF >> (8 * nb));
`ifndef ABSORB_ZERO_MASK_EN
        keep = 64'hFFFF_FFFF_FFFF_FFFF;
`endif
        return w & keep;
    endfunction

    function automatic void push_exp(input logic [63:0] d, input int nb, input bit pe, input bit lwib, input bit fin);
        exp_t e;
        e.data = d; e.rvb = 4'(nb); e.pe = pe; e.lwib = lwib; e.fin = fin;
        exp_q.push_back(e);
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_data_out"}, data_out, 64'd0);
        chk({tag, "_rvb"}, 64'(remaining_valid_bytes), 64'd0);
        chk({tag, "_pe"}, 64'(padding_enable), 64'd0);
        chk({tag, "_lwib"}, 64'(last_word_in_block), 64'd0);
        chk({tag, "_preset"}, 64'(padding_reset), 64'd0);
        chk({tag, "_done"}, 64'(absorb_done), 64'd0);
        chk({tag, "_din_ready"}, 64'(din_ready), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        din_valid = 1'b0;
        din_last  = 1'b0;
        start     = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_outputs(tag);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_done();
        int d0;
        int to;
        d0 = done_cnt;
        to = 0;
        while (done_cnt == d0 && to < 600) begin
            @(negedge clk);
            to++;
        end
        if (done_cnt == d0) chk("absorb_done_timeout", 64'd0, 64'd1);
        @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    // Sends one message; abort_after>0 asserts rst right after that many accepted words
    task automatic send_msg(input int n, input int last_bytes, input int abort_after,
                            input bit fixed_en, input logic [63:0] fixed_word);
        int pos;
        int to;
        int pad;
        int nb;
        logic [63:0] w;
        pos = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            if (i == n - 1 && fixed_en) w = fixed_word;
            nb = (i == n - 1) ? last_bytes : 8;
            if (gaps) begin
                din_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            din = w; din_bytes = 4'(nb); din_last = (i == n - 1); din_valid = 1'b1;
            to = 0;
            @(negedge clk);
            while (!din_ready && to < 100) begin
                to++;
                @(negedge clk);
            end
            if (!din_ready) begin
                chk("din_accept_timeout", 64'd0, 64'd1);
                din_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            push_exp(model_data(w, nb), nb, nb < 8, (pos % RW) == RW - 1,
                     (i == n - 1) && (nb < 8) && ((pos % RW) == RW - 1));
            pos++;
            if (abort_after == i + 1) begin
                do_reset("midrst");
                return;
            end
        end
        din_valid = 1'b0;
        din_last  = 1'b0;
        pad = (last_bytes == 8) ? (RW - pos % RW) : ((RW - pos % RW) % RW);
        for (int p = 0; p < pad; p++) begin
            push_exp(64'd0, 0, 1'b1, (pos % RW) == RW - 1, p == pad - 1);
            pos++;
        end
        wait_done();
    endtask

    // out_ready pattern: steady, alternating, or random
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output transfer and checks pulses/stalls
    initial begin
        bit          done_exp = 1'b0;
        bit          pr_exp = 1'b0;
        bit          stall_prev = 1'b0;
        logic [63:0] held = 64'd0;
        bit          done_n;
        bit          pr_n;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_exp = 1'b0; pr_exp = 1'b0; stall_prev = 1'b0;
                continue;
            end
            if (absorb_done || done_exp) chk("absorb_done", 64'(absorb_done), 64'(done_exp));
            if (padding_reset || pr_exp) chk("padding_reset", 64'(padding_reset), 64'(pr_exp));
            if (absorb_done) done_cnt++;
            if (stall_prev) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", data_out, held);
            end
            done_n = 1'b0;
            pr_n   = start;
            if (out_valid && !out_ready) chk("din_ready_stall", 64'(din_ready), 64'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", data_out, 64'd0);
                    chk("unexpected_word_count", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_out", data_out, e.data);
                    chk("rvb", 64'(remaining_valid_bytes), 64'(e.rvb));
                    chk("padding_enable", 64'(padding_enable), 64'(e.pe));
                    chk("lwib", 64'(last_word_in_block), 64'(e.lwib));
                    if (e.fin) begin
                        done_n = 1'b1;
                        pr_n   = 1'b1;
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = data_out;
            done_exp   = done_n;
            pr_exp     = pr_n;
        end
    end

    initial begin
        #1 rst = 1'b1;
        #5 check_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        send_msg(3, 5, 0, 1'b0, 64'd0);
        send_msg(17, 8, 0, 1'b0, 64'd0);
        send_msg(1, 0, 0, 1'b0, 64'd0);
        send_msg(16, 4, 0, 1'b0, 64'd0);

        ready_mode = 1;
        send_msg(25, 3, 0, 1'b0, 64'd0);
        ready_mode = 0;

        send_msg(40, 8, 9, 1'b0, 64'd0);
        send_msg(2, 6, 0, 1'b0, 64'd0);

        send_msg(1, 3, 0, 1'b1, 64'hAABBCCDDEEFF1122);

        ready_mode = 2;
        gaps = 1'b1;
        for (int t = 0; t < 6; t++) begin
            send_msg(int'($urandom_range(1, 40)), int'($urandom_range(0, 8)), 0, 1'b0, 64'd0);
        end
        ready_mode = 0;
        gaps = 1'b0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
